// File: rtl/uart_byte_receiver.sv
// uart_byte_receiver: oversampled asynchronous UART receiver feeding command_decoder.
// Default frame is 8N1. Defining UART_RX_PARITY_EN switches the frame to 8E1 and adds
// the PARITY state. Each bit is decided by a 2-of-3 majority vote taken around mid-bit.
// byte_ready is stretched to READY_HOLD cycles, because the decoder waits for it to fall
// between bytes.
module uart_byte_receiver #(
    parameter int CLKS_PER_TICK = 54,
    parameter int OVERSAMPLE    = 16,
    parameter int READY_HOLD    = 4,
    parameter int SYNC_STAGES   = 2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       rx,
    output logic [7:0] byte_out,
    output logic       byte_ready,
    output logic       frame_error,
    output logic       busy
);

    localparam int TW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam int OW = $clog2(OVERSAMPLE);
    localparam int RW = $clog2(READY_HOLD + 1);

    localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_TICK - 1);
    localparam logic [OW-1:0] OS_LAST   = OW'(OVERSAMPLE - 1);
    localparam logic [OW-1:0] SMP_A     = OW'(OVERSAMPLE / 2 - 1);
    localparam logic [OW-1:0] SMP_B     = OW'(OVERSAMPLE / 2);
    localparam logic [OW-1:0] SMP_C     = OW'(OVERSAMPLE / 2 + 1);
    localparam logic [RW-1:0] HOLD_LOAD = RW'(READY_HOLD);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] rx_sync_p0;
    logic                   rs;
    logic                   rs_p1;

    logic [TW-1:0] tick_cnt;
    logic [OW-1:0] os_cnt;
    logic [2:0]    bit_cnt;
    logic [RW-1:0] ready_cnt;

    logic [1:0] smp_q;
    logic [7:0] shift_q;

    logic tick;
    logic at_a;
    logic at_b;
    logic at_c;
    logic bit_end;
    logic maj;

    logic shift_en;
    logic load_byte;
    logic fe_set;

`ifdef UART_RX_PARITY_EN
    logic par_err_q;
`endif

    // Two-of-three vote over the samples taken around the middle of a bit.
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    assign rs      = rx_sync_p0[SYNC_STAGES-1];
    assign tick    = (tick_cnt == TICK_LAST);
    assign at_a    = tick && (os_cnt == SMP_A);
    assign at_b    = tick && (os_cnt == SMP_B);
    assign at_c    = tick && (os_cnt == SMP_C);
    assign bit_end = tick && (os_cnt == OS_LAST);
    // The third vote is the live sample at tick M+1, so the decision needs no extra cycle.
    assign maj     = majority3(smp_q[0], smp_q[1], rs);

    assign byte_ready = (ready_cnt != '0);
    assign busy       = (state_q != S_IDLE);

    // Stage p0: synchronise rx; p1: previous synchronised value for falling-edge detection.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_sync_p0 <= '1;
            rs_p1      <= 1'b1;
        end else begin
            rx_sync_p0 <= {rx_sync_p0[SYNC_STAGES-2:0], rx};
            rs_p1      <= rs;
        end
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-cycle strobes.
    always_comb begin
        state_d   = state_q;
        shift_en  = 1'b0;
        load_byte = 1'b0;
        fe_set    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rs_p1 && !rs) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (at_c && maj) begin
                    state_d = S_IDLE;
                end else if (bit_end) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                shift_en = at_c;
                if (bit_end && (bit_cnt == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
                    state_d = S_PARITY;
`else
                    state_d = S_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (at_c) begin
`ifdef UART_RX_PARITY_EN
                    if (maj && !par_err_q) begin
`else
                    if (maj) begin
`endif
                        load_byte = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        fe_set  = 1'b1;
                        state_d = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                // The bit timer only runs while the line is high, so bit_end means one
                // uninterrupted idle bit time has been seen.
                if (bit_end) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Tick and oversample counters; parked at zero in IDLE and while BREAK sees the line low.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt <= '0;
            os_cnt   <= '0;
        end else if ((state_q == S_IDLE) || ((state_q == S_BREAK) && !rs)) begin
            tick_cnt <= '0;
            os_cnt   <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
            os_cnt   <= (os_cnt == OS_LAST) ? '0 : os_cnt + OW'(1);
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    // Data bit index; wraps back to zero after bit 7.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt <= '0;
        end else if (state_q == S_IDLE) begin
            bit_cnt <= '0;
        end else if ((state_q == S_DATA) && bit_end) begin
            bit_cnt <= bit_cnt + 3'd1;
        end
    end

    // Mid-bit samples and the LSB-first shift register (pure datapath, no reset).
    always_ff @(posedge clock) begin
        if (at_a) begin
            smp_q[0] <= rs;
        end
        if (at_b) begin
            smp_q[1] <= rs;
        end
        if (shift_en) begin
            shift_q <= {maj, shift_q[7:1]};
        end
    end

`ifdef UART_RX_PARITY_EN
    // Even parity check over data plus parity bit; consumed by the STOP decision.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            par_err_q <= 1'b0;
        end else if ((state_q == S_PARITY) && at_c) begin
            par_err_q <= ^{shift_q, maj};
        end
    end
`endif

    // Output byte and error pulse; byte_out only changes on a good frame.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            byte_out    <= '0;
            frame_error <= 1'b0;
        end else begin
            frame_error <= fe_set;
            if (load_byte) begin
                byte_out <= shift_q;
            end
        end
    end

    // byte_ready stretch counter, independent of the FSM so the next start edge is not blocked.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ready_cnt <= '0;
        end else if (load_byte) begin
            ready_cnt <= HOLD_LOAD;
        end else if (ready_cnt != '0) begin
            ready_cnt <= ready_cnt - RW'(1);
        end
    end

endmodule

// File: tb/tb_uart_byte_receiver.sv
// Bench for uart_byte_receiver with CLKS_PER_TICK=4, OVERSAMPLE=16 (64 clocks per bit),
// READY_HOLD=4. Define UART_RX_PARITY_EN for both files to exercise the 8E1 build.
module tb_uart_byte_receiver;

    localparam int CPT  = 4;
    localparam int OS   = 16;
    localparam int HOLD = 4;
    localparam int BIT  = CPT * OS;
`ifdef UART_RX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic       clock   = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx      = 1'b1;
    logic [7:0] byte_out;
    logic       byte_ready;
    logic       frame_error;
    logic       busy;

    always #5 clock = ~clock;

    uart_byte_receiver #(
        .CLKS_PER_TICK(CPT),
        .OVERSAMPLE   (OS),
        .READY_HOLD   (HOLD),
        .SYNC_STAGES  (2)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .rx         (rx),
        .byte_out   (byte_out),
        .byte_ready (byte_ready),
        .frame_error(frame_error),
        .busy       (busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Monitor state: every byte_ready pulse is logged with its byte and length.
    logic [7:0] got_byte [0:63];
    int         rdy_len  [0:63];
    int         rdy_rises = 0;
    int         cur_len   = 0;
    logic       rdy_prev  = 1'b0;
    int         fe_rises  = 0;
    int         fe_cur    = 0;
    int         fe_max    = 0;
    logic       fe_prev   = 1'b0;
    int         overlap   = 0;

    logic [7:0] last_good = 8'h00;

    always @(negedge clock) begin
        if (byte_ready && !rdy_prev) begin
            got_byte[rdy_rises[5:0]] <= byte_out;
            rdy_rises <= rdy_rises + 1;
            cur_len   <= 1;
        end else if (byte_ready) begin
            cur_len <= cur_len + 1;
        end else if (rdy_prev) begin
            rdy_len[6'(rdy_rises - 1)] <= cur_len;
        end
        rdy_prev <= byte_ready;

        if (frame_error && !fe_prev) begin
            fe_rises <= fe_rises + 1;
            fe_cur   <= 1;
        end else if (frame_error) begin
            fe_cur <= fe_cur + 1;
        end else if (fe_prev && (fe_cur > fe_max)) begin
            fe_max <= fe_cur;
        end
        fe_prev <= frame_error;

        if (byte_ready && frame_error) begin
            overlap <= overlap + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Wire image of one frame, bit 0 = start bit, with correct parity when enabled.
    function automatic logic [FB-1:0] make_frame(input logic [7:0] d, input logic stp);
        logic [FB-1:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = d;
`ifdef UART_RX_PARITY_EN
        f[9]   = ^d;
`endif
        f[FB-1] = stp;
        return f;
    endfunction

    // Reference decision: a frame is good if start is low, stop is high and parity is even.
    function automatic logic model_ok(input logic [FB-1:0] f);
        logic ok;
        ok = (f[0] == 1'b0) && (f[FB-1] == 1'b1);
`ifdef UART_RX_PARITY_EN
        ok = ok && ((^f[9:1]) == 1'b0);
`endif
        return ok;
    endfunction

    task automatic send_bits(input logic [FB-1:0] f);
        for (int i = 0; i < FB; i++) begin
            rx = f[i];
            idle(BIT);
        end
    endtask

    // Send one frame, let the line recover if it was bad, and compare against the model.
    task automatic frame_check(input string tag, input logic [FB-1:0] f);
        int   r0;
        int   e0;
        logic ok;
        r0 = rdy_rises;
        e0 = fe_rises;
        ok = model_ok(f);
        send_bits(f);
        if (!ok) begin
            if (!f[FB-1]) begin
                idle(BIT);
            end
            rx = 1'b1;
            idle(2 * BIT);
        end else begin
            idle(8);
        end
        check({tag, " ready pulses"}, 32'(rdy_rises - r0), ok ? 32'd1 : 32'd0);
        check({tag, " error pulses"}, 32'(fe_rises - e0), ok ? 32'd0 : 32'd1);
        if (ok) begin
            last_good = f[8:1];
            check({tag, " pulse byte"}, 32'(got_byte[r0[5:0]]), 32'(f[8:1]));
            check({tag, " pulse len"}, 32'(rdy_len[r0[5:0]]), 32'(HOLD));
        end
        check({tag, " byte_out"}, 32'(byte_out), 32'(last_good));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int            r0;
        int            e0;
        int            waited;
        logic [7:0]    cmd [0:4];
        logic [7:0]    d;
        logic          stp;
        logic [FB-1:0] f;

        // Reset values
        reset_n = 1'b0;
        rx      = 1'b1;
        idle(3);
        check("reset byte_out", 32'(byte_out), 32'h00);
        check("reset byte_ready", 32'(byte_ready), 32'd0);
        check("reset frame_error", 32'(frame_error), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        idle(BIT);

        // Single byte
        frame_check("a5", make_frame(8'hA5, 1'b1));

        // Two frames with zero idle gap
        r0 = rdy_rises;
        send_bits(make_frame(8'h4F, 1'b1));
        send_bits(make_frame(8'hD1, 1'b1));
        idle(8);
        check("b2b pulses", 32'(rdy_rises - r0), 32'd2);
        check("b2b first", 32'(got_byte[r0[5:0]]), 32'h4F);
        check("b2b second", 32'(got_byte[6'(r0 + 1)]), 32'hD1);
        check("b2b len", 32'(rdy_len[6'(r0 + 1)]), 32'(HOLD));
        last_good = 8'hD1;

        // Short low glitch is rejected
        r0 = rdy_rises;
        e0 = fe_rises;
        rx = 1'b0;
        idle(20);
        check("glitch busy high", 32'(busy), 32'd1);
        rx = 1'b1;
        waited = 0;
        while (busy && (waited < BIT)) begin
            idle(1);
            waited++;
        end
        check("glitch busy drop", 32'(busy), 32'd0);
        idle(BIT);
        check("glitch ready", 32'(rdy_rises - r0), 32'd0);
        check("glitch error", 32'(fe_rises - e0), 32'd0);

        // Bad stop bit with line held low for three bit times
        r0 = rdy_rises;
        e0 = fe_rises;
        send_bits(make_frame(8'h3C, 1'b0));
        idle(2 * BIT);
        check("break error pulses", 32'(fe_rises - e0), 32'd1);
        check("break error len", 32'(fe_max), 32'd1);
        check("break ready", 32'(rdy_rises - r0), 32'd0);
        check("break byte_out", 32'(byte_out), 32'(last_good));
        check("break busy low line", 32'(busy), 32'd1);
        rx = 1'b1;
        idle(40);
        check("break busy mid idle", 32'(busy), 32'd1);
        idle(40);
        check("break busy released", 32'(busy), 32'd0);
        frame_check("after break 11", make_frame(8'h11, 1'b1));

`ifdef UART_RX_PARITY_EN
        // Parity good and bad
        frame_check("parity good 07", make_frame(8'h07, 1'b1));
        f    = make_frame(8'h07, 1'b1);
        f[9] = 1'b0;
        frame_check("parity bad 07", f);
`endif

        // Reset during the data bits of 0xFF
        r0 = rdy_rises;
        rx = 1'b0;
        idle(BIT);
        rx = 1'b1;
        idle(3 * BIT);
        reset_n = 1'b0;
        idle(2);
        check("midreset byte_out", 32'(byte_out), 32'h00);
        check("midreset byte_ready", 32'(byte_ready), 32'd0);
        check("midreset frame_error", 32'(frame_error), 32'd0);
        check("midreset busy", 32'(busy), 32'd0);
        reset_n   = 1'b1;
        last_good = 8'h00;
        idle(6 * BIT);
        check("midreset no ready", 32'(rdy_rises - r0), 32'd0);
        frame_check("after reset 55", make_frame(8'h55, 1'b1));

        // Command sequence for the decoder, back to back
        cmd[0] = 8'h01;
        cmd[1] = 8'h12;
        cmd[2] = 8'h34;
        cmd[3] = 8'h56;
        cmd[4] = 8'h78;
        r0 = rdy_rises;
        for (int i = 0; i < 5; i++) begin
            send_bits(make_frame(cmd[i], 1'b1));
        end
        idle(8);
        check("cmd pulses", 32'(rdy_rises - r0), 32'd5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("cmd byte %0d", i), 32'(got_byte[6'(r0 + i)]), 32'(cmd[i]));
        end
        last_good = 8'h78;

        // Randomised frames against the model
        for (int k = 0; k < 12; k++) begin
            d   = 8'($urandom);
            stp = ($urandom_range(0, 3) != 0);
            f   = make_frame(d, stp);
`ifdef UART_RX_PARITY_EN
            if ($urandom_range(0, 5) == 0) begin
                f[9] = ~f[9];
            end
`endif
            idle($urandom_range(0, 30));
            frame_check($sformatf("rand%0d", k), f);
        end

        check("ready/error overlap", 32'(overlap), 32'd0);
        check("error pulse width", 32'(fe_max), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
